multicycle_ctrl: RTL

- Multicycle sequencer that drives the existing single-cycle datapath's 12-bit control bundle {regwrite, alusrcA, alusrcB, jump, memwrite, memread, memtoreg, alucontrol[3:0], selBranch}.
- Fetches each instruction over a req/ready handshake and holds it in an instruction register feeding the datapath `instr` input.
- Decodes the supported RV32I subset and gates all architectural side effects (register write, memory write, PC update) to one commit cycle per instruction.
- Adds a retired-instruction counter, a data-memory timeout watchdog and an illegal-instruction trap.

---
 rtl/multicycle_ctrl_if.sv | 19 +
 rtl/multicycle_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// Instruction-fetch and data-memory handshake between the multicycle
// sequencer (master) and its memories (slave).
interface multicycle_ctrl_if;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_ready;

  modport master (
    output imem_req, dmem_req,
    input  imem_ready, imem_rdata, dmem_ready
  );

  modport slave (
    input  imem_req, dmem_req,
    output imem_ready, imem_rdata, dmem_ready
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer for the single-cycle datapath: fetch, decode, one
// commit cycle per instruction, retired counter, memory watchdog, trap.
module multicycle_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clock,
  input  logic                reset,
  multicycle_ctrl_if.master   bus,
  output logic [31:0]         instr,
  output logic                regwrite,
  output logic                alusrcA,
  output logic                alusrcB,
  output logic                jump,
  output logic                memwrite,
  output logic                memread,
  output logic                memtoreg,
  output logic                selBranch,
  output logic [3:0]          alucontrol,
  output logic                pc_en,
  output logic [CNT_W-1:0]    instret,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef struct packed {
    logic       rw;
    logic       a;
    logic       b;
    logic       j;
    logic       mw;
    logic       mr;
    logic       mt;
    logic [3:0] alu;
    logic       sel;
  } ctrl_t;

  localparam int          WAIT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [31:0] TIMEOUT_U = TIMEOUT;

  state_t            st;
  ctrl_t             ctrl_q;
  ctrl_t             dec_ctrl;
  logic              dec_legal;
  logic              dec_mem;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_hit;
  logic              commit;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    dec_ctrl  = '0;
    dec_legal = 1'b1;
    dec_mem   = 1'b0;
    case (opcode)
      7'b0010011: begin
        if (funct3 == 3'b000) dec_ctrl = {7'b1110000, 4'b0010, 1'b0};
        else                  dec_legal = 1'b0;
      end
      7'b0110011: begin
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: dec_ctrl = {7'b1100000, 4'b0010, 1'b0};
          {7'b0100000, 3'b000}: dec_ctrl = {7'b1100000, 4'b1010, 1'b0};
          {7'b0000000, 3'b010}: dec_ctrl = {7'b1100000, 4'b1011, 1'b0};
          default:              dec_legal = 1'b0;
        endcase
      end
      7'b1100011: begin
        if      (funct3 == 3'b000) dec_ctrl = {7'b0100000, 4'b1010, 1'b1};
        else if (funct3 == 3'b100) dec_ctrl = {7'b0100000, 4'b1011, 1'b1};
        else                       dec_legal = 1'b0;
      end
      7'b1101111: dec_ctrl = {7'b0011000, 4'b0010, 1'b0};
      7'b0000011: begin
        dec_mem = 1'b1;
        if (funct3 == 3'b010) dec_ctrl = {7'b1110011, 4'b0010, 1'b0};
        else                  dec_legal = 1'b0;
      end
      7'b0100011: begin
        dec_mem = 1'b1;
        if (funct3 == 3'b010) dec_ctrl = {7'b0110100, 4'b0010, 1'b0};
        else                  dec_legal = 1'b0;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Counter value includes the current MEM cycle; a same-cycle ready still commits.
  assign timeout_hit = (TIMEOUT > 0) && ((32'(wait_cnt) + 32'd1) >= TIMEOUT_U);
  assign commit      = (st == EXEC) || ((st == MEM) && bus.dmem_ready);

  assign bus.imem_req = (st == FETCH);
  assign bus.dmem_req = (st == MEM);

  assign pc_en      = commit;
  assign regwrite   = commit & ctrl_q.rw;
  assign memwrite   = commit & ctrl_q.mw;
  assign alusrcA    = ctrl_q.a;
  assign alusrcB    = ctrl_q.b;
  assign jump       = ctrl_q.j;
  assign memread    = ctrl_q.mr;
  assign memtoreg   = ctrl_q.mt;
  assign alucontrol = ctrl_q.alu;
  assign selBranch  = ctrl_q.sel;
  assign state      = st;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      st         <= IDLE;
      instr      <= '0;
      ctrl_q     <= '0;
      instret    <= '0;
      trap       <= 1'b0;
      trap_cause <= 2'b00;
      wait_cnt   <= '0;
    end else begin
      if (commit) instret <= instret + CNT_W'(1);
      case (st)
        IDLE: st <= FETCH;
        FETCH: begin
          if (bus.imem_ready) begin
            instr <= bus.imem_rdata;
            st    <= DECODE;
          end
        end
        DECODE: begin
          if (!dec_legal) begin
            ctrl_q     <= '0;
            trap       <= 1'b1;
            trap_cause <= 2'b01;
            st         <= TRAP;
          end else begin
            ctrl_q <= dec_ctrl;
            st     <= dec_mem ? MEM : EXEC;
          end
        end
        EXEC: begin
          ctrl_q <= '0;
          st     <= FETCH;
        end
        MEM: begin
          if (bus.dmem_ready) begin
            ctrl_q   <= '0;
            wait_cnt <= '0;
            st       <= FETCH;
          end else if (timeout_hit) begin
            ctrl_q     <= '0;
            wait_cnt   <= '0;
            trap       <= 1'b1;
            trap_cause <= 2'b10;
            st         <= TRAP;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        TRAP: st <= TRAP;
        default: st <= IDLE;
      endcase
    end
  end

endmodule
